// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state encoding and grant helpers for the 4-master bus arbiter.
package bus_arbiter_pkg;

   localparam int unsigned BUS_MASTER_CH = 4;
   localparam int unsigned BUS_OWNER_W   = 2;
   localparam int unsigned ARB_STATE_W   = 2;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_0 = 2'd0;
   localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_1 = 2'd1;
   localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_2 = 2'd2;
   localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_3 = 2'd3;

   typedef logic [BUS_MASTER_CH-1:0] bus_vec_t;
   typedef logic [BUS_OWNER_W-1:0]   bus_owner_t;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_PARK = 2'd2
   } arb_state_e;

   // Active-low vector with only the given master's bit cleared.
   function automatic bus_vec_t grant_mask(input bus_owner_t owner);
      return ~(BUS_MASTER_CH'(1) << owner);
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Active-low request/grant bundle between the four bus masters and the arbiter.
interface bus_arbiter_if;
   import bus_arbiter_pkg::*;

   logic       m0_req_, m1_req_, m2_req_, m3_req_;
   logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
   bus_owner_t owner;
   logic       busy;

   modport master (
      output m0_req_, m1_req_, m2_req_, m3_req_,
      input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, busy
   );

   modport slave (
      input  m0_req_, m1_req_, m2_req_, m3_req_,
      output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, busy
   );

endinterface

// File: rtl/bus_rr_pick.sv
// Combinational round-robin pick: search owner+1, owner+2, owner+3, owner for the
// first active-low request (rotate, priority-encode, unrotate).
module bus_rr_pick
   import bus_arbiter_pkg::*;
(
   input  bus_vec_t   req_n_i,
   input  bus_owner_t owner_i,
   output bus_owner_t win_o,
   output logic       any_o
);

   bus_vec_t   act;
   bus_vec_t   rot;
   bus_owner_t off;

   always_comb begin
      act = ~req_n_i;
      // rot[i] is the request of master owner+1+i
      rot = BUS_MASTER_CH'({act, act} >> (3'(owner_i) + 3'd1));
      off = '0;
      for (int i = BUS_MASTER_CH - 1; i >= 0; i--) begin
         if (rot[i]) off = 2'(i);
      end
      win_o = owner_i + 2'd1 + off;
      any_o = |act;
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 4-master bus with a hold limit that preempts
// a long tenure, through a one-cycle PARK gap, once another master is waiting.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic          clk,
   input  logic          reset,
   bus_arbiter_if.slave  bus
);

   localparam bit               HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EN ? MAX_HOLD - 1 : 0);
   localparam logic [CNT_W-1:0] HOLD_SAT  = '1;

   arb_state_e       state_q, state_d;
   bus_owner_t       owner_q, owner_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   bus_vec_t         grnt_q, grnt_d;
   logic             busy_q, busy_d;

   bus_vec_t         req_n;
   bus_owner_t       win;
   logic             any;
   logic             owner_req;
   logic             others;

   assign req_n = {bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

   bus_rr_pick u_pick (
      .req_n_i (req_n),
      .owner_i (owner_q),
      .win_o   (win),
      .any_o   (any)
   );

   assign owner_req = (req_n[owner_q] == ENABLE_);
   assign others    = |(~req_n & grant_mask(owner_q));

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      hold_d  = hold_q;
      unique case (state_q)
         ARB_BUSY: begin
            if (owner_req) begin
               // >= so a saturated counter still preempts when a waiter shows up late
               if (HOLD_EN && (hold_q >= HOLD_LAST) && others) begin
                  state_d = ARB_PARK;
                  hold_d  = '0;
               end else if (hold_q != HOLD_SAT) begin
                  hold_d = hold_q + CNT_W'(1);
               end
            end else if (any) begin
               owner_d = win;
               hold_d  = '0;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         default: begin
            if (any) begin
               state_d = ARB_BUSY;
               owner_d = win;
               hold_d  = '0;
            end else begin
               state_d = ARB_IDLE;
            end
         end
      endcase
      grnt_d = (state_d == ARB_BUSY) ? grant_mask(owner_d) : {BUS_MASTER_CH{DISABLE_}};
      busy_d = (state_d == ARB_BUSY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         owner_q <= BUS_OWNER_MASTER_3;
         hold_q  <= '0;
         grnt_q  <= {BUS_MASTER_CH{DISABLE_}};
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         grnt_q  <= grnt_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.m0_grnt_ = grnt_q[BUS_OWNER_MASTER_0];
   assign bus.m1_grnt_ = grnt_q[BUS_OWNER_MASTER_1];
   assign bus.m2_grnt_ = grnt_q[BUS_OWNER_MASTER_2];
   assign bus.m3_grnt_ = grnt_q[BUS_OWNER_MASTER_3];
   assign bus.owner    = owner_q;
   assign bus.busy     = busy_q;

endmodule
